// File: rtl/ortho_ray_gen.sv
// Orthographic ray source: scans a WIDTH x HEIGHT raster and emits one
// 6-word double-precision ray per pixel on an AXI-stream, origin per pixel, direction (0,0,-1).
module ortho_ray_gen #(
  parameter int              SIZE        = 64,
  parameter int              WIDTH       = 320,
  parameter int              HEIGHT      = 240,
  parameter int              SCALE_SHIFT = 7,
  parameter logic [63:0]     CAM_Z       = 64'h4024000000000000
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 start,
  output logic                 busy,
  output logic                 frame_done,
  output logic [5:0][SIZE-1:0] ray_axis_tdata,
  output logic                 ray_axis_tvalid,
  input  logic                 ray_axis_tready,
  output logic                 ray_axis_tlast,
  output logic [31:0]          ray_axis_tuser
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [15:0] X_LAST  = 16'(WIDTH - 1);
  localparam logic [15:0] Y_LAST  = 16'(HEIGHT - 1);
  localparam logic [63:0] NEG_ONE = 64'hBFF0000000000000;

  state_t                state, state_next;
  logic [15:0]           px, py, nx, ny;
  logic signed [16:0]    sx, sy;
  logic [5:0][SIZE-1:0]  beat_next;
  logic                  hs, at_last, load;

  // Exact signed-integer to double conversion, value = v * 2^-SCALE_SHIFT.
  // A 17-bit magnitude always fits the 52-bit mantissa, so no rounding.
  function automatic logic [63:0] to_double(input logic signed [16:0] v);
    logic [16:0] m;
    logic [51:0] mant;
    logic [10:0] e;
    int          k;
    m = v[16] ? 17'(-v) : 17'(v);
    k = 0;
    for (int i = 0; i < 17; i++) begin
      if (m[i]) k = i;
    end
    // Shifting the MSB to bit 52 pushes the implicit leading one out of the field.
    mant = 52'(m) << (52 - k);
    e    = 11'(1023 + k - SCALE_SHIFT);
    if (m == '0) return 64'h0;
    return {v[16], e, mant};
  endfunction

  assign hs         = ray_axis_tvalid && ray_axis_tready;
  assign at_last    = (px == X_LAST) && (py == Y_LAST);
  assign busy       = (state == RUN);
  assign frame_done = (state == DONE);

  // Next pixel and its beat, precomputed so a handshake can load it immediately.
  always_comb begin
    nx = '0;
    ny = '0;
    if (state == RUN) begin
      if (px == X_LAST) begin
        nx = '0;
        ny = py + 16'd1;
      end else begin
        nx = px + 16'd1;
        ny = py;
      end
    end
    sx = 17'(nx) - 17'(WIDTH / 2);
    sy = 17'(HEIGHT / 2) - 17'(ny);
    beat_next[0] = SIZE'(to_double(sx));
    beat_next[1] = SIZE'(to_double(sy));
    beat_next[2] = SIZE'(CAM_Z);
    beat_next[3] = '0;
    beat_next[4] = '0;
    beat_next[5] = SIZE'(NEG_ONE);
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          load       = 1'b1;
        end
      end
      RUN: begin
        if (hs) begin
          if (at_last) state_next = DONE;
          else         load       = 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state           <= IDLE;
      px              <= '0;
      py              <= '0;
      ray_axis_tdata  <= '0;
      ray_axis_tuser  <= '0;
      ray_axis_tlast  <= 1'b0;
      ray_axis_tvalid <= 1'b0;
    end else begin
      state <= state_next;
      if (load) begin
        px              <= nx;
        py              <= ny;
        ray_axis_tdata  <= beat_next;
        ray_axis_tuser  <= {ny, nx};
        ray_axis_tlast  <= (nx == X_LAST) && (ny == Y_LAST);
        ray_axis_tvalid <= 1'b1;
      end else if (state == RUN && hs && at_last) begin
        px              <= '0;
        py              <= '0;
        ray_axis_tlast  <= 1'b0;
        ray_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule
